// File: rtl/sl_serializer.sv
// Two-line pulse serializer: pops one word per frame from an async FIFO and
// sends it MSB first plus odd parity as pulses on sl1 (one bits) / sl0 (zero bits).
module sl_serializer #(
  parameter int DATA_SIZE   = 8,
  parameter int BIT_PERIOD  = 4,
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_inc,
  output logic                 sl0,
  output logic                 sl1,
  output logic                 busy,
  output logic                 frame_done
);

  // The bit counter is shared between data/parity slots and gap bits.
  localparam int BIT_MAX = (DATA_SIZE > GAP_BITS - 1) ? DATA_SIZE : GAP_BITS - 1;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int PH_W    = $clog2(BIT_PERIOD);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE);
  localparam logic [BIT_W-1:0] LAST_GAP = BIT_W'(GAP_BITS - 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(BIT_PERIOD - 1);
  localparam logic [PH_W-1:0]  PULSE_PH = PH_W'(PULSE_WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state_q, state_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [DATA_SIZE:0]   shift_q, shift_d;
  logic                 sl0_q, sl0_d;
  logic                 sl1_q, sl1_d;
  logic                 armed_q;
  logic                 phase_end;
  logic                 pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      phase_q <= '0;
      shift_q <= '0;
      sl0_q   <= 1'b0;
      sl1_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      sl0_q   <= sl0_d;
      sl1_q   <= sl1_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    fifo_inc   = 1'b0;
    frame_done = 1'b0;
    phase_end  = (phase_q == LAST_PH);

    case (state_q)
      IDLE: begin
        // armed_q holds off the first pop until a clock edge has seen reset released
        if (armed_q && enable && !fifo_empty) begin
          fifo_inc = 1'b1;
          state_d  = SEND;
          bit_d    = '0;
          phase_d  = '0;
          shift_d  = {fifo_data, ~^fifo_data};
        end
      end
      SEND: begin
        if (phase_end) begin
          phase_d = '0;
          shift_d = shift_q << 1;
          if (bit_q == LAST_BIT) begin
            state_d = GAP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      GAP: begin
        if (phase_end) begin
          phase_d = '0;
          if (bit_q == LAST_GAP) begin
            state_d    = IDLE;
            bit_d      = '0;
            frame_done = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line outputs are registered, so they are derived from the next-cycle slot.
    pulse_d = (state_d == SEND) && (phase_d < PULSE_PH);
    sl1_d   = pulse_d && shift_d[DATA_SIZE];
    sl0_d   = pulse_d && !shift_d[DATA_SIZE];
  end

  assign sl0  = sl0_q;
  assign sl1  = sl1_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sl_serializer.sv
// Randomized scoreboard bench for sl_serializer: a FIFO model feeds words, a
// negedge monitor predicts every output from the capture time of each frame.
module tb_sl_serializer;

  localparam int DS    = 8;
  localparam int BP    = 4;
  localparam int PW    = 2;
  localparam int GB    = 4;
  localparam int FRAME = (DS + 1 + GB) * BP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DS-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_inc, sl0, sl1, busy, frame_done;

  sl_serializer #(.DATA_SIZE(DS), .BIT_PERIOD(BP), .PULSE_WIDTH(PW), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_inc(fifo_inc), .sl0(sl0), .sl1(sl1),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            pops = 0;
  bit            pop_flag = 1'b0;
  logic [DS-1:0] fifo_q[$];
  logic [DS-1:0] exp_q[$];

  bit            in_frame = 1'b0;
  bit            hold = 1'b1;
  int            t0 = 0;
  logic [DS:0]   exp_bits, obs_bits;

  function automatic logic [DS:0] line_bits(input logic [DS-1:0] w);
    logic par;
    par = ($countones(w) % 2 == 0);
    return {w, par};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [DS-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    $display("push word %h (queued %0d)", w, fifo_q.size());
    refresh();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pop(input int lim);
    int start;
    start = pops;
    for (int i = 0; i < lim && pops == start; i++) @(posedge clk);
    #2;
    checks++;
    if (pops == start) begin
      errors++;
      $display("FAIL pop_timeout cycle %0d: got no fifo_inc expected one within %0d cycles", cyc, lim);
    end
  endtask

  // FIFO read side: pop after the edge on which the DUT captured the head word.
  always @(posedge clk) begin
    #1;
    if (pop_flag) begin
      pop_flag = 1'b0;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  // Monitor: outputs packed as {fifo_inc, busy, frame_done, sl1, sl0}.
  always @(negedge clk) begin
    logic [4:0] act, expv;
    int c, k, p;
    act = {fifo_inc, busy, frame_done, sl1, sl0};
    if (!rst_n) begin
      check("reset_outputs", {27'd0, act}, 32'd0);
      in_frame = 1'b0;
      hold     = 1'b1;
    end else if (in_frame) begin
      c    = cyc - t0;
      expv = {1'b0, 1'b1, (c == FRAME), 2'b00};
      if (c <= (DS + 1) * BP) begin
        k = (c - 1) / BP;
        p = (c - 1) % BP;
        if (p < PW) expv[1:0] = exp_bits[DS-k] ? 2'b10 : 2'b01;
        if (p == 0) obs_bits[DS-k] = sl1;
      end
      check("frame_outputs", {27'd0, act}, {27'd0, expv});
      if (c == FRAME) begin
        check("decoded_word", {23'd0, obs_bits}, {23'd0, exp_bits});
        $display("frame done: sent %h cycle %0d", obs_bits, cyc);
        in_frame = 1'b0;
      end
    end else begin
      expv = {(enable && !fifo_empty && !hold), 4'b0000};
      check("idle_outputs", {27'd0, act}, {27'd0, expv});
      hold = 1'b0;
      if (fifo_inc) begin
        pop_flag = 1'b1;
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty cycle %0d: got fifo_inc expected no pop", cyc);
        end else begin
          exp_bits = line_bits(exp_q.pop_front());
          obs_bits = '0;
          in_frame = 1'b1;
          t0       = cyc;
          $display("pop at cycle %0d, expect line bits %h", cyc, exp_bits);
        end
      end
    end
    cyc++;
  end

  initial begin
    rst_n = 1'b0;
    step(4);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(3);

    push_word(8'hA5);
    step(60);
    push_word(8'h00);
    step(60);

    push_word(8'h5A);
    push_word(8'hFF);
    push_word(8'h81);
    step(170);

    step(100);

    push_word(8'h3C);
    wait_pop(20);
    step(9);
    enable = 1'b0;
    push_word(8'h96);
    step(100);
    enable = 1'b1;
    wait_pop(20);
    step(60);

    push_word(8'h12);
    push_word(8'h34);
    wait_pop(20);
    step(19);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wait_pop(20);
    step(60);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
      enable = ($urandom_range(0, 4) != 0);
      step($urandom_range(1, 40));
    end
    enable = 1'b1;
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || in_frame); i++) step(1);
    step(5);
    check("leftover_words", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
